// File: rtl/ascon_input_sequencer.sv
// ascon_input_sequencer: upstream feeder for the ASCON-128 control FSM.
// Collects a 32-bit word stream (key, nonce, then 5 x 64-bit blocks: one AD
// block followed by NB_PT_BLOCKS plaintext blocks), keeps key/nonce frozen for
// the datapath, presents blocks through a one-deep staging buffer and uses the
// FSM's data-XOR strobe as block acknowledge and its done strobe as end of op.
//
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   i_sys_enable         0 behaves like reset but keeps o_error
//   i_word/_valid        stream word and valid; o_word_ready accepts it
//   i_xor_data_begin     block acknowledge from the FSM
//   i_done               end-of-operation strobe from the FSM
//   o_start              one-cycle start pulse to the FSM
//   o_data_valid/o_data  pending block for the FSM
//   o_key, o_nonce       operation key and nonce
//   o_busy               operation in progress
//   o_error              sticky protocol error
module ascon_input_sequencer #(
  parameter int unsigned NB_PT_BLOCKS = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_sys_enable,
  input  logic [31:0]  i_word,
  input  logic         i_word_valid,
  output logic         o_word_ready,
  input  logic         i_xor_data_begin,
  input  logic         i_done,
  output logic         o_start,
  output logic         o_data_valid,
  output logic [63:0]  o_data,
  output logic [127:0] o_key,
  output logic [127:0] o_nonce,
  output logic         o_busy,
  output logic         o_error
);

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BLK_W     = 64;
  localparam int unsigned FIELD_W   = 128;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned NB_BLOCKS = NB_PT_BLOCKS + 1;
  localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(NB_BLOCKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KEY,
    S_LOAD_NONCE,
    S_START,
    S_RUN,
    S_WAIT_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           word_cnt_q, word_cnt_d;
  logic [FIELD_W-1:0]   key_q, key_d;
  logic [FIELD_W-1:0]   nonce_q, nonce_d;
  logic [BLK_W-1:0]     data_q, data_d;
  logic                 data_valid_q, data_valid_d;
  logic [WORD_W-1:0]    hi_word_q, hi_word_d;
  logic                 hi_valid_q, hi_valid_d;
  logic [BLK_W-1:0]     stage_q, stage_d;
  logic                 stage_full_q, stage_full_d;
  logic [CNT_W-1:0]     blk_cnt_q, blk_cnt_d;
  logic [CNT_W-1:0]     ack_cnt_q, ack_cnt_d;
  logic                 word_ready_q, word_ready_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic                 error_q, error_d;

  logic accept;
  logic ack;
  logic proto_err;

  // Place a word into a 128-bit field; index 0 is the most significant word.
  function automatic logic [FIELD_W-1:0] put_word(input logic [FIELD_W-1:0] field,
                                                  input logic [1:0]         idx,
                                                  input logic [WORD_W-1:0]  word);
    logic [FIELD_W-1:0] r;
    r = field;
    case (idx)
      2'd0:    r[127:96] = word;
      2'd1:    r[95:64]  = word;
      2'd2:    r[63:32]  = word;
      default: r[31:0]   = word;
    endcase
    return r;
  endfunction

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    key_d        = key_q;
    nonce_d      = nonce_q;
    data_d       = data_q;
    data_valid_d = data_valid_q;
    hi_word_d    = hi_word_q;
    hi_valid_d   = hi_valid_q;
    stage_d      = stage_q;
    stage_full_d = stage_full_q;
    blk_cnt_d    = blk_cnt_q;
    ack_cnt_d    = ack_cnt_q;
    error_d      = error_q;
    word_ready_d = 1'b0;
    start_d      = 1'b0;
    busy_d       = 1'b0;

    accept    = i_word_valid && word_ready_q;
    ack       = i_xor_data_begin;
    proto_err = (ack && !data_valid_q) || (i_done && (state_q != S_WAIT_DONE));

    if (proto_err) begin
      // Protocol violation: abandon the operation, keep key/nonce/data contents.
      error_d      = 1'b1;
      state_d      = S_IDLE;
      word_cnt_d   = 2'd0;
      data_valid_d = 1'b0;
      hi_valid_d   = 1'b0;
      stage_full_d = 1'b0;
      blk_cnt_d    = '0;
      ack_cnt_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            key_d      = put_word(key_q, 2'd0, i_word);
            word_cnt_d = 2'd1;
            state_d    = S_LOAD_KEY;
          end
        end
        S_LOAD_KEY: begin
          if (accept) begin
            key_d      = put_word(key_q, word_cnt_q, i_word);
            word_cnt_d = word_cnt_q + 2'd1;
            if (word_cnt_q == 2'd3) state_d = S_LOAD_NONCE;
          end
        end
        S_LOAD_NONCE: begin
          if (accept) begin
            nonce_d    = put_word(nonce_q, word_cnt_q, i_word);
            word_cnt_d = word_cnt_q + 2'd1;
            if (word_cnt_q == 2'd3) state_d = S_START;
          end
        end
        S_START: begin
          state_d = S_RUN;
        end
        S_RUN: begin
          // Acknowledge retires the presented block; a staged block replaces it.
          if (ack) begin
            ack_cnt_d = ack_cnt_q + 3'd1;
            if (stage_full_q) begin
              data_d       = stage_q;
              stage_full_d = 1'b0;
            end else begin
              data_valid_d = 1'b0;
            end
          end
          // Word assembly; a completed block bypasses staging when the output is free.
          if (accept) begin
            if (!hi_valid_q) begin
              hi_word_d  = i_word;
              hi_valid_d = 1'b1;
            end else begin
              hi_valid_d = 1'b0;
              blk_cnt_d  = blk_cnt_q + 3'd1;
              if (!data_valid_q || ack) begin
                data_d       = {hi_word_q, i_word};
                data_valid_d = 1'b1;
              end else begin
                stage_d      = {hi_word_q, i_word};
                stage_full_d = 1'b1;
              end
            end
          end
          if (ack_cnt_d == LAST_BLK) state_d = S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (i_done) begin
            state_d   = S_IDLE;
            blk_cnt_d = '0;
            ack_cnt_d = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Outputs are registered, so they follow the state being entered.
    busy_d  = (state_d != S_IDLE);
    start_d = (state_d == S_START);
    case (state_d)
      S_IDLE, S_LOAD_KEY, S_LOAD_NONCE: word_ready_d = 1'b1;
      S_RUN:   word_ready_d = !stage_full_d && (blk_cnt_d < LAST_BLK);
      default: word_ready_d = 1'b0;
    endcase
  end

  // State register; disable clears everything except the sticky error.
  always_ff @(posedge clock) begin
    if (reset || !i_sys_enable) begin
      state_q      <= S_IDLE;
      word_cnt_q   <= 2'd0;
      key_q        <= '0;
      nonce_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      hi_word_q    <= '0;
      hi_valid_q   <= 1'b0;
      stage_q      <= '0;
      stage_full_q <= 1'b0;
      blk_cnt_q    <= '0;
      ack_cnt_q    <= '0;
      word_ready_q <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      if (reset) error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      key_q        <= key_d;
      nonce_q      <= nonce_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      hi_word_q    <= hi_word_d;
      hi_valid_q   <= hi_valid_d;
      stage_q      <= stage_d;
      stage_full_q <= stage_full_d;
      blk_cnt_q    <= blk_cnt_d;
      ack_cnt_q    <= ack_cnt_d;
      word_ready_q <= word_ready_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
    end
  end

  assign o_word_ready = word_ready_q;
  assign o_start      = start_q;
  assign o_data_valid = data_valid_q;
  assign o_data       = data_q;
  assign o_key        = key_q;
  assign o_nonce      = nonce_q;
  assign o_busy       = busy_q;
  assign o_error      = error_q;

endmodule

// File: tb/tb_ascon_input_sequencer.sv
// Testbench for ascon_input_sequencer: transaction-level model of the word
// stream (words 0-3 key, 4-7 nonce, 8-17 blocks) with a pending-block queue,
// compared against every registered output each cycle, plus literal checks.
module tb_ascon_input_sequencer;

  logic         clock = 1'b0;
  logic         reset;
  logic         i_sys_enable;
  logic [31:0]  i_word;
  logic         i_word_valid;
  logic         o_word_ready;
  logic         i_xor_data_begin;
  logic         i_done;
  logic         o_start;
  logic         o_data_valid;
  logic [63:0]  o_data;
  logic [127:0] o_key;
  logic [127:0] o_nonce;
  logic         o_busy;
  logic         o_error;

  always #5 clock = ~clock;

  ascon_input_sequencer #(.NB_PT_BLOCKS(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .i_sys_enable     (i_sys_enable),
    .i_word           (i_word),
    .i_word_valid     (i_word_valid),
    .o_word_ready     (o_word_ready),
    .i_xor_data_begin (i_xor_data_begin),
    .i_done           (i_done),
    .o_start          (o_start),
    .o_data_valid     (o_data_valid),
    .o_data           (o_data),
    .o_key            (o_key),
    .o_nonce          (o_nonce),
    .o_busy           (o_busy),
    .o_error          (o_error)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit pct(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 key, 2 nonce, 3 start, 4 run, 5 wait-done
  int           m_phase = 0;
  int           m_words = 0;
  int           m_acks  = 0;
  logic [127:0] m_key   = '0;
  logic [127:0] m_nonce = '0;
  logic [63:0]  m_cur   = '0;
  logic [31:0]  m_hi    = '0;
  logic [63:0]  m_pend[$];
  bit m_valid = 0, m_ready = 0, m_start = 0, m_busy = 0, m_err = 0, m_accepted = 0;

  task automatic model_abort();
    m_phase = 0; m_words = 0; m_acks = 0; m_valid = 0;
    m_pend.delete();
  endtask

  task automatic model_step();
    bit acc;
    m_accepted = 0;
    if (reset || !i_sys_enable) begin
      model_abort();
      m_key = '0; m_nonce = '0; m_cur = '0; m_hi = '0;
      if (reset) m_err = 0;
      m_ready = 0; m_start = 0; m_busy = 0;
      return;
    end
    acc = i_word_valid && m_ready;
    if ((i_xor_data_begin && !m_valid) || (i_done && m_phase != 5)) begin
      m_err = 1;
      model_abort();
    end else begin
      m_accepted = acc;
      case (m_phase)
        0, 1, 2: if (acc) begin
          if (m_words < 4) m_key[127 - 32*m_words -: 32] = i_word;
          else m_nonce[127 - 32*(m_words-4) -: 32] = i_word;
          m_words++;
          m_phase = (m_words < 4) ? 1 : (m_words < 8) ? 2 : 3;
        end
        3: m_phase = 4;
        4: begin
          if (i_xor_data_begin) begin
            m_acks++;
            if (m_pend.size() > 0) m_cur = m_pend.pop_front();
            else m_valid = 0;
          end
          if (acc) begin
            if ((m_words - 8) % 2 == 0) m_hi = i_word;
            else if (!m_valid) begin m_cur = {m_hi, i_word}; m_valid = 1; end
            else m_pend.push_back({m_hi, i_word});
            m_words++;
          end
          if (m_acks == 5) m_phase = 5;
        end
        default: if (i_done) model_abort();
      endcase
    end
    m_ready = (m_phase <= 2) || (m_phase == 4 && m_pend.size() == 0 && m_words < 18);
    m_start = (m_phase == 3);
    m_busy  = (m_phase != 0);
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // Single compare process: every output against the model each cycle.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("word_ready", 128'(o_word_ready), 128'(m_ready));
      chk("start",      128'(o_start),      128'(m_start));
      chk("data_valid", 128'(o_data_valid), 128'(m_valid));
      chk("data",       128'(o_data),       128'(m_cur));
      chk("key",        o_key,              m_key);
      chk("nonce",      o_nonce,            m_nonce);
      chk("busy",       128'(o_busy),       128'(m_busy));
      chk("error",      128'(o_error),      128'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  logic [63:0] op_blk [5];

  task automatic idle_inputs();
    reset = 1'b0; i_sys_enable = 1'b1; i_word_valid = 1'b0; i_word = '0;
    i_xor_data_begin = 1'b0; i_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    idle_inputs();
  endtask

  // mode: 0 full op, 1 early done, 2 spurious ack, 3 reset mid-run, 4 disable mid-run
  task automatic run_op(input logic [127:0] k, input logic [127:0] n, input int mode,
                        input int hold, input int ack_pct, input int vld_pct,
                        input logic exp_err);
    logic [31:0] w [18];
    logic [63:0] first_data = '0;
    int idx = 0, cyc = 0, nonce_cyc = -100, start_cyc = -200, n_start = 0;
    int hold_left = hold, bp = 0;
    bit fired = 0, left_idle = 0, finished = 0, got_first = 0;
    for (int i = 0; i < 4; i++) begin
      w[i]     = k[127 - 32*i -: 32];
      w[4 + i] = n[127 - 32*i -: 32];
    end
    for (int i = 0; i < 5; i++) begin
      w[8 + 2*i] = op_blk[i][63:32];
      w[9 + 2*i] = op_blk[i][31:0];
    end
    while (!finished && cyc < 3000) begin
      @(negedge clock);
      cyc++;
      if (m_accepted) begin
        if (idx == 7) nonce_cyc = cyc - 1;
        idx++;
      end
      if (o_start) begin n_start++; start_cyc = cyc; end
      if (o_data_valid && !got_first) begin got_first = 1; first_data = o_data; end
      if (bp == 3) begin
        chk("bp_release_data",  128'(o_data),       128'(op_blk[1]));
        chk("bp_release_valid", 128'(o_data_valid), 128'(1));
        bp = 4;
      end
      if (m_phase != 0) left_idle = 1;
      if (left_idle && m_phase == 0) begin
        finished = 1;
      end else begin
        idle_inputs();
        i_word_valid = (idx < 18) && pct(vld_pct);
        i_word       = (idx < 18) ? w[idx] : '0;
        if (m_valid) begin
          if (bp == 0 && hold_left > 0 && m_acks == 0) begin
            hold_left--;
            if (hold_left == 0) begin
              chk("bp_ready", 128'(o_word_ready), 128'(0));
              chk("bp_data",  128'(o_data),       128'(op_blk[0]));
              chk("bp_valid", 128'(o_data_valid), 128'(1));
              bp = 2;
            end
          end else if (bp == 2) begin
            i_xor_data_begin = 1'b1;
            bp = 3;
          end else begin
            i_xor_data_begin = pct(ack_pct);
          end
        end
        if (m_phase == 5 && pct(50)) i_done = 1'b1;
        if (!fired) begin
          if ((mode == 1 && m_phase == 4 && m_acks == 2) ||
              (mode == 2 && m_phase == 2) ||
              (mode >= 3 && m_phase == 4 && m_acks >= 1)) begin
            fired = 1;
            i_word_valid = 1'b0;
            i_xor_data_begin = (mode == 2);
            i_done = (mode == 1);
            reset = (mode == 3);
            i_sys_enable = (mode != 4);
          end
        end
      end
    end
    idle_inputs();
    chk("op_finished", 128'(finished), 128'(1));
    chk("op_error",    128'(o_error),  128'(exp_err));
    chk("op_busy",     128'(o_busy),   128'(0));
    if (mode == 0) begin
      chk("start_count",   128'(n_start),             128'(1));
      chk("start_latency", 128'(start_cyc - nonce_cyc), 128'(1));
      chk("first_block",   128'(first_data),          128'(op_blk[0]));
      chk("key_held",      o_key,                     k);
      chk("nonce_held",    o_nonce,                   n);
    end else if (mode <= 2) begin
      chk("err_valid", 128'(o_data_valid), 128'(0));
      chk("err_ready", 128'(o_word_ready), 128'(1));
    end else begin
      chk("abort_ready", 128'(o_word_ready), 128'(0));
      chk("abort_valid", 128'(o_data_valid), 128'(0));
      chk("abort_data",  128'(o_data),       128'(0));
      chk("abort_key",   o_key,              128'(0));
      chk("abort_nonce", o_nonce,            128'(0));
    end
  endtask

  task automatic rand_blocks();
    for (int i = 0; i < 5; i++) op_blk[i] = {$urandom, $urandom};
  endtask

  localparam logic [127:0] NOM_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] NOM_NONCE = 128'h101112131415161718191a1b1c1d1e1f;

  initial begin
    reset = 1'b1; i_sys_enable = 1'b1; i_word_valid = 1'b0; i_word = '0;
    i_xor_data_begin = 1'b0; i_done = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk_en = 1'b1;
    chk("rst_ready", 128'(o_word_ready), 128'(0));
    chk("rst_start", 128'(o_start),      128'(0));
    chk("rst_valid", 128'(o_data_valid), 128'(0));
    chk("rst_data",  128'(o_data),       128'(0));
    chk("rst_key",   o_key,              128'(0));
    chk("rst_nonce", o_nonce,            128'(0));
    chk("rst_busy",  128'(o_busy),       128'(0));
    chk("rst_error", 128'(o_error),      128'(0));
    idle_inputs();
    @(negedge clock);

    // Nominal operation
    op_blk[0] = 64'h4120746f20736179;
    op_blk[1] = 64'h0011223344556677;
    op_blk[2] = 64'h8899aabbccddeeff;
    op_blk[3] = 64'hdeadbeefcafef00d;
    op_blk[4] = 64'h0123456789abcdef;
    run_op(NOM_KEY, NOM_NONCE, 0, 0, 60, 80, 1'b0);
    // Back-pressure: ack withheld for 20 cycles with words offered
    run_op(NOM_KEY, NOM_NONCE, 0, 20, 50, 100, 1'b0);
    // Reset mid-run, then an immediate fresh operation
    rand_blocks();
    run_op({$urandom, $urandom, $urandom, $urandom}, NOM_NONCE, 3, 0, 50, 90, 1'b0);
    run_op(NOM_KEY, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 70, 100, 1'b0);
    // Spurious ack during nonce load
    run_op(NOM_KEY, NOM_NONCE, 2, 0, 50, 90, 1'b1);
    do_reset();
    // Early done after 2 acks, then error survives a full operation and a disable
    rand_blocks();
    run_op(NOM_KEY, NOM_NONCE, 1, 0, 50, 90, 1'b1);
    run_op(NOM_NONCE, NOM_KEY, 0, 0, 50, 90, 1'b1);
    chk("err_sticky", 128'(o_error), 128'(1));
    run_op(NOM_KEY, NOM_NONCE, 4, 0, 50, 90, 1'b1);
    run_op(NOM_KEY, NOM_NONCE, 0, 0, 90, 100, 1'b1);
    do_reset();

    // Randomized operations
    for (int t = 0; t < 10; t++) begin
      rand_blocks();
      run_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
             0, (t % 3 == 0) ? int'($urandom_range(15, 5)) : 0,
             int'($urandom_range(90, 20)), int'($urandom_range(100, 30)), 1'b0);
      repeat (int'($urandom_range(3))) @(negedge clock);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
